// File: rtl/periph_bus_responder.sv
// periph_bus_responder: memory-mapped timer, LED, 7-segment scanner and systick
module periph_bus_responder #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic [7:0]  leds,
  output logic [3:0]  tube_an,
  output logic [7:0]  tube_seg,
  output logic        irq
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0]   th_q, th_d, tl_q, tl_d, systick_q, systick_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [7:0]    led_q, led_d, seg_q, seg_d;
  logic [15:0]   digits_q, digits_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic          sel, mapped, ovf, wrap, unused_ok;
  logic [5:0]    off;
  assign unused_ok = ^Address[1:0];
  assign sel    = Address[31:8] == 24'h400000;
  assign off    = Address[7:2];
  assign mapped = sel && off <= 6'd5;
  assign ovf    = tcon_q[0] && tl_q == 32'hFFFF_FFFF;
  assign wrap   = scan_q == SCAN_MAX;
  assign leds     = led_q;
  assign tube_an  = an_q;
  assign tube_seg = seg_q;
  assign irq      = tcon_q[1] & tcon_q[2];
  // read mux: pure function of current state, so a same-cycle write shows the old value
  always_comb begin
    Read_Data = !(MemRead && mapped) ? 32'h0 :
                off == 6'd0 ? th_q :
                off == 6'd1 ? tl_q :
                off == 6'd2 ? {29'h0, tcon_q} :
                off == 6'd3 ? {24'h0, led_q} :
                off == 6'd4 ? {16'h0, digits_q} : systick_q;
  end
  // next-state: bus writes take priority over timer increment/reload and status set
  always_comb begin
    th_d      = MemWrite && sel && off == 6'd0 ? Write_Data : th_q;
    tl_d      = MemWrite && sel && off == 6'd1 ? Write_Data :
                ovf ? th_q : tcon_q[0] ? tl_q + 32'd1 : tl_q;
    tcon_d    = MemWrite && sel && off == 6'd2 ? Write_Data[2:0] :
                {tcon_q[2] | (ovf & tcon_q[1]), tcon_q[1:0]};
    led_d     = MemWrite && sel && off == 6'd3 ? Write_Data[7:0] : led_q;
    digits_d  = MemWrite && sel && off == 6'd4 ? Write_Data[15:0] : digits_q;
    systick_d = systick_q + 32'd1;
    scan_d    = wrap ? '0 : scan_q + 1'b1;
    idx_d     = idx_q + 2'(wrap);
    an_d      = ~(4'b0001 << idx_d);
    seg_d     = HEX[digits_d[{idx_d, 2'b00} +: 4]];
  end
  // state registers; segment decode uses next-state digits so a write shows at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digits_q  <= '0;
      systick_q <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1110;
      seg_q     <= 8'hC0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end
endmodule
